hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline interlock and HI/LO multi-cycle sequencer for the 5-stage core. It sits beside the EX-stage forwarding muxes and decides when forwarding alone is insufficient. Cases handled: a load in ME whose data only exists at WB (load-use), and an in-flight multiply/divide that has not yet written HI/LO. It issues the mul/div start pulse, tracks latency, freezes IF/ID/EX and injects a bubble into ME while a hazard is unresolved.

## Interface
- MUL_CYCLES, 2, cycles from md_start to md_done for mult/multu (must be >= 2)
- DIV_CYCLES, 33, cycles from md_start to md_done for div/divu (must be >= 2)

- clk  in  1  clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- EX_valid  in  1  EX holds a live instruction
- EX_src1_used / EX_src2_used  in  1 each  source operand is read by the EX instruction
- EX_src1_addr / EX_src2_addr  in  5 each  source register numbers
- EX_md_op  in  2  00 none, 01 mult, 10 div, 11 reserved (treated as none)
- EX_hilo_read  in  1  EX instruction is mfhi/mflo
- ME_valid  in  1  ME holds a live instruction
- ME_is_load  in  1  ME instruction is a load
- ME_reg_waddr  in  5  ME destination register
- flush  in  1  exception/eret flush of IF..EX this cycle
- md_start  out  1  one-cycle start pulse to mul/div unit
- md_busy  out  1  operation in flight
- md_done  out  1  one-cycle pulse, HI/LO write enable for the result
- front_stall  out  1  hold IF, ID, EX registers
- ME_bubble  out  1  load a nop into ME next edge
- stall_cnt  out  16  saturating count of stalled cycles

## Operation
- lu_hazard = EX_valid & ME_valid & ME_is_load & (ME_reg_waddr != 0) & ((EX_src1_used & EX_src1_addr == ME_reg_waddr) | (EX_src2_used & EX_src2_addr == ME_reg_waddr)).
- md_hazard = (state != IDLE) & EX_valid & (EX_md_op in {01,10} | EX_hilo_read).
- front_stall = ME_bubble = (lu_hazard | md_hazard) & ~flush.
- md_start = (state == IDLE) & EX_valid & EX_md_op in {01,10} & ~lu_hazard & ~flush.
- FSM states: IDLE, BUSY, DONE.
  - IDLE -> BUSY on md_start; cnt <= (mult ? MUL_CYCLES : DIV_CYCLES) - 1.
  - BUSY: if cnt == 1 -> DONE, else cnt <= cnt - 1.
  - DONE -> IDLE unconditionally.
- md_busy = (state != IDLE). md_done = (state == DONE).
- flush never aborts an in-flight operation, because it is older than every flushed instruction. flush only suppresses md_start and stall outputs in its cycle.
- stall_cnt += 1 on each cycle front_stall = 1; holds at 0xFFFF.
- cnt width = ceil(log2(max(MUL_CYCLES, DIV_CYCLES))) + 1.

## Timing
- While resetn = 0: state IDLE, cnt 0, stall_cnt 0. Every output is 0, including the combinational md_start, front_stall and ME_bubble.
- Reset asserted mid-operation aborts it with no md_done.
- Outputs are combinational from inputs and state in the same cycle; no input-to-output register stage.
- Load-use costs exactly 1 stall cycle. Next cycle the load is in WB, lu_hazard drops and the WB forward path supplies the data.
- md_start in cycle T -> md_done in cycle T+MUL_CYCLES or T+DIV_CYCLES. md_busy is high T+1 .. T+LAT.
- The md instruction itself is not stalled; it proceeds past EX in cycle T.
- A dependent mfhi/mflo or a second md op in EX stalls through the DONE cycle. It proceeds in the cycle after md_done.
- If lu_hazard and md op coincide in IDLE, md_start is deferred until the cycle the EX instruction is released.

## Test plan
- lw r5 in ME, EX reads r5 as src2 -> front_stall = ME_bubble = 1 for exactly 1 cycle, stall_cnt +1; same with ME_reg_waddr = 0 -> no stall.
- mult in EX from IDLE -> md_start in T, md_busy T+1..T+2, md_done in T+2 only (MUL_CYCLES = 2).
- div, then mflo in EX at T+1 -> front_stall held T+1..T+33, released at T+34, md_done at T+33.
- div in flight, flush pulse at T+5 with mfhi in EX -> no stall that cycle, md_done still at T+33.
- resetn dropped at T+10 of a div -> outputs 0 immediately, no md_done afterwards, a new mult after release completes in 2 cycles.
- Force 70000 consecutive stall cycles -> stall_cnt saturates at 0xFFFF.

Source files
------------

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use interlock and HI/LO multiply/divide latency sequencer
module hazard_ctrl #(
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 33
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        EX_valid,
    input  logic        EX_src1_used,
    input  logic        EX_src2_used,
    input  logic [4:0]  EX_src1_addr,
    input  logic [4:0]  EX_src2_addr,
    input  logic [1:0]  EX_md_op,
    input  logic        EX_hilo_read,
    input  logic        ME_valid,
    input  logic        ME_is_load,
    input  logic [4:0]  ME_reg_waddr,
    input  logic        flush,
    output logic        md_start,
    output logic        md_busy,
    output logic        md_done,
    output logic        front_stall,
    output logic        ME_bubble,
    output logic [15:0] stall_cnt
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES) + 1;
    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          is_md, src1_hit, src2_hit, lu_hazard, md_hazard, stall;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            stall_cnt <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (stall && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end

    // Combinational outputs are gated by resetn so they read 0 throughout reset.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_md       = (EX_md_op == 2'b01) || (EX_md_op == 2'b10);
        src1_hit    = EX_src1_used && (EX_src1_addr == ME_reg_waddr);
        src2_hit    = EX_src2_used && (EX_src2_addr == ME_reg_waddr);
        lu_hazard   = EX_valid && ME_valid && ME_is_load && (ME_reg_waddr != 5'd0)
                      && (src1_hit || src2_hit);
        md_hazard   = (state_q != IDLE) && EX_valid && (is_md || EX_hilo_read);
        stall       = resetn && (lu_hazard || md_hazard) && !flush;
        md_start    = resetn && (state_q == IDLE) && EX_valid && is_md && !lu_hazard && !flush;
        front_stall = stall;
        ME_bubble   = stall;
        md_busy     = (state_q != IDLE);
        md_done     = (state_q == DONE);

        case (state_q)
            IDLE: if (md_start) begin
                state_d = BUSY;
                cnt_d   = (EX_md_op == 2'b01) ? MUL_LOAD : DIV_LOAD;
            end
            BUSY: if (cnt_q == CNT_ONE) state_d = DONE;
                  else                  cnt_d   = cnt_q - CNT_ONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl against a cycle-count reference model
module tb_hazard_ctrl;

    localparam int MUL = 2;
    localparam int DIV = 33;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic        EX_valid, EX_src1_used, EX_src2_used, EX_hilo_read;
    logic [4:0]  EX_src1_addr, EX_src2_addr, ME_reg_waddr;
    logic [1:0]  EX_md_op;
    logic        ME_valid, ME_is_load, flush;
    logic        md_start, md_busy, md_done, front_stall, ME_bubble;
    logic [15:0] stall_cnt;

    hazard_ctrl #(.MUL_CYCLES(MUL), .DIV_CYCLES(DIV)) dut (
        .clk(clk), .resetn(resetn),
        .EX_valid(EX_valid), .EX_src1_used(EX_src1_used), .EX_src2_used(EX_src2_used),
        .EX_src1_addr(EX_src1_addr), .EX_src2_addr(EX_src2_addr),
        .EX_md_op(EX_md_op), .EX_hilo_read(EX_hilo_read),
        .ME_valid(ME_valid), .ME_is_load(ME_is_load), .ME_reg_waddr(ME_reg_waddr),
        .flush(flush),
        .md_start(md_start), .md_busy(md_busy), .md_done(md_done),
        .front_stall(front_stall), .ME_bubble(ME_bubble), .stall_cnt(stall_cnt)
    );

    typedef struct {
        logic       ev, s1u, s2u;
        logic [4:0] a1, a2;
        logic [1:0] op;
        logic       hilo, mv, ml;
        logic [4:0] mwa;
        logic       fl;
        logic       e_stall, e_start;
    } vec_t;

    vec_t tbl[13];

    int n_cmp = 0, n_bad = 0;
    int cyc = 0;
    int md_end = -1;        // cycle in which the model expects md_done
    int m_stall_cnt = 0;
    logic o_start, o_busy, o_done, o_stall, o_bubble;
    logic [15:0] o_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic idle_inputs();
        EX_valid = 0; EX_src1_used = 0; EX_src2_used = 0; EX_hilo_read = 0;
        EX_src1_addr = 0; EX_src2_addr = 0; EX_md_op = 0;
        ME_valid = 0; ME_is_load = 0; ME_reg_waddr = 0; flush = 0;
    endtask

    task automatic set_lu_hazard();
        EX_valid = 1; EX_src2_used = 1; EX_src2_addr = 5'd5;
        ME_valid = 1; ME_is_load = 1; ME_reg_waddr = 5'd5;
    endtask

    task automatic set_ex(input logic [1:0] op, input logic hilo);
        idle_inputs();
        EX_valid = 1; EX_md_op = op; EX_hilo_read = hilo;
    endtask

    // One clock: compare at negedge against the model, advance the model at posedge.
    task automatic tick();
        logic is_md, lu, busy, done, mdh, e_stall, e_start;
        @(negedge clk);
        is_md = (EX_md_op == 2'd1) || (EX_md_op == 2'd2);
        lu = EX_valid && ME_valid && ME_is_load && (ME_reg_waddr != 0) &&
             ((EX_src1_used && EX_src1_addr == ME_reg_waddr) ||
              (EX_src2_used && EX_src2_addr == ME_reg_waddr));
        busy    = (md_end >= cyc);
        done    = (md_end == cyc);
        mdh     = busy && EX_valid && (is_md || EX_hilo_read);
        e_stall = (lu || mdh) && !flush;
        e_start = !busy && EX_valid && is_md && !lu && !flush;
        o_start = md_start; o_busy = md_busy; o_done = md_done;
        o_stall = front_stall; o_bubble = ME_bubble; o_cnt = stall_cnt;
        chk("md_start", o_start, e_start);
        chk("md_busy", o_busy, busy);
        chk("md_done", o_done, done);
        chk("front_stall", o_stall, e_stall);
        chk("ME_bubble", o_bubble, e_stall);
        chk("stall_cnt", o_cnt, m_stall_cnt);
        @(posedge clk);
        if (e_start) md_end = cyc + ((EX_md_op == 2'd1) ? MUL : DIV);
        if (e_stall && m_stall_cnt < 65535) m_stall_cnt++;
        cyc++;
        #1;
    endtask

    // Called at posedge+1; asserts reset with hazardous inputs present and checks all outputs are 0.
    task automatic do_reset();
        resetn = 0;
        set_lu_hazard(); EX_md_op = 2'd2; EX_hilo_read = 1;
        #1;
        chk("rst md_start", md_start, 0);
        chk("rst md_busy", md_busy, 0);
        chk("rst md_done", md_done, 0);
        chk("rst front_stall", front_stall, 0);
        chk("rst ME_bubble", ME_bubble, 0);
        chk("rst stall_cnt", stall_cnt, 0);
        md_end = -1; m_stall_cnt = 0;
        @(posedge clk); cyc++;
        @(posedge clk); cyc++;
        #1;
        resetn = 1;
        idle_inputs();
    endtask

    initial begin
        //        ev s1u s2u a1 a2 op hilo mv ml mwa fl  stall start
        tbl[0]  = '{1, 0, 1, 0, 5, 0, 0, 1, 1, 5, 0, 1, 0};  // lw r5, src2 r5
        tbl[1]  = '{1, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0};  // r0 destination
        tbl[2]  = '{1, 1, 0, 7, 0, 0, 0, 1, 1, 7, 0, 1, 0};  // src1 match
        tbl[3]  = '{1, 0, 0, 7, 7, 0, 0, 1, 1, 7, 0, 0, 0};  // match but unused
        tbl[4]  = '{1, 1, 1, 7, 7, 0, 0, 1, 0, 7, 0, 0, 0};  // ME not a load
        tbl[5]  = '{1, 1, 1, 7, 7, 0, 0, 0, 1, 7, 0, 0, 0};  // ME invalid
        tbl[6]  = '{0, 1, 1, 7, 7, 1, 0, 1, 1, 7, 0, 0, 0};  // EX invalid
        tbl[7]  = '{1, 1, 1, 1, 2, 1, 0, 1, 1, 3, 0, 0, 1};  // mult, no hazard
        tbl[8]  = '{1, 1, 0, 3, 0, 2, 0, 1, 1, 3, 0, 1, 0};  // div deferred by load-use
        tbl[9]  = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0};  // mult suppressed by flush
        tbl[10] = '{1, 0, 1, 0, 5, 0, 0, 1, 1, 5, 1, 0, 0};  // load-use under flush
        tbl[11] = '{1, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0};  // reserved op
        tbl[12] = '{1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};  // mfhi while idle

        resetn = 0;
        idle_inputs();
        do_reset();

        for (int i = 0; i < 13; i++) begin
            do_reset();
            EX_valid = tbl[i].ev; EX_src1_used = tbl[i].s1u; EX_src2_used = tbl[i].s2u;
            EX_src1_addr = tbl[i].a1; EX_src2_addr = tbl[i].a2; EX_md_op = tbl[i].op;
            EX_hilo_read = tbl[i].hilo; ME_valid = tbl[i].mv; ME_is_load = tbl[i].ml;
            ME_reg_waddr = tbl[i].mwa; flush = tbl[i].fl;
            tick();
            chk($sformatf("tbl%0d stall", i), o_stall, tbl[i].e_stall);
            chk($sformatf("tbl%0d bubble", i), o_bubble, tbl[i].e_stall);
            chk($sformatf("tbl%0d start", i), o_start, tbl[i].e_start);
        end

        // load-use: exactly one stall cycle, counter +1
        do_reset();
        set_lu_hazard();
        tick();
        chk("lu stall", o_stall, 1);
        ME_valid = 0;
        tick();
        chk("lu release", o_stall, 0);
        chk("lu stall_cnt", o_cnt, 1);

        // mult latency
        set_ex(2'd1, 0);
        tick();
        chk("mult start", o_start, 1);
        idle_inputs();
        tick();
        chk("mult busy T+1", o_busy, 1);
        chk("mult done T+1", o_done, 0);
        tick();
        chk("mult busy T+2", o_busy, 1);
        chk("mult done T+2", o_done, 1);
        tick();
        chk("mult idle T+3", o_busy, 0);

        // div then dependent mflo
        set_ex(2'd2, 0);
        tick();
        chk("div start", o_start, 1);
        set_ex(2'd0, 1);
        for (int k = 1; k <= 33; k++) begin
            tick();
            chk($sformatf("mflo stall T+%0d", k), o_stall, 1);
            chk($sformatf("div done T+%0d", k), o_done, (k == 33));
        end
        tick();
        chk("mflo release T+34", o_stall, 0);

        // div with flush while mfhi waits
        set_ex(2'd2, 0);
        tick();
        idle_inputs();
        for (int k = 1; k <= 33; k++) begin
            if (k == 5) begin set_ex(2'd0, 1); flush = 1; end
            tick();
            if (k == 5) begin chk("flush no stall", o_stall, 0); idle_inputs(); end
            chk($sformatf("flushed div done T+%0d", k), o_done, (k == 33));
        end
        tick();

        // reset mid-divide
        set_ex(2'd2, 0);
        tick();
        idle_inputs();
        repeat (9) tick();
        do_reset();
        for (int k = 0; k < 40; k++) begin
            tick();
            chk("no done after reset", o_done, 0);
        end
        set_ex(2'd1, 0);
        tick();
        chk("post-reset mult start", o_start, 1);
        idle_inputs();
        tick();
        tick();
        chk("post-reset mult done", o_done, 1);

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            int r;
            EX_valid = ($urandom_range(0, 3) != 0);
            EX_src1_used = $urandom_range(0, 1); EX_src2_used = $urandom_range(0, 1);
            EX_src1_addr = 5'($urandom_range(0, 3)); EX_src2_addr = 5'($urandom_range(0, 3));
            r = $urandom_range(0, 9);
            EX_md_op = (r < 3) ? 2'(r + 1) : 2'd0;
            EX_hilo_read = ($urandom_range(0, 4) == 0);
            ME_valid = $urandom_range(0, 1); ME_is_load = $urandom_range(0, 1);
            ME_reg_waddr = 5'($urandom_range(0, 3));
            flush = ($urandom_range(0, 9) == 0);
            tick();
        end

        // stall counter saturation
        do_reset();
        set_lu_hazard();
        repeat (70000) tick();
        idle_inputs();
        tick();
        chk("stall_cnt saturated", o_cnt, 16'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
